// File: rtl/ddrphy_cmd_launch.sv
// ddrphy_cmd_launch: DFI command/address to DRAM pins via programmable posedge delay, negedge launch, optional 2T.
// Defining DDRPHY_CA_PARITY_EN adds the registered CA parity output par.
module ddrphy_cmd_launch #(
  parameter int CS_WIDTH   = 1,
  parameter int BA_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_DLY    = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dfi_cke,
  input  logic [CS_WIDTH-1:0]          dfi_cs_n,
  input  logic                         dfi_ras_n,
  input  logic                         dfi_cas_n,
  input  logic                         dfi_we_n,
  input  logic [BA_WIDTH-1:0]          dfi_ba,
  input  logic [ADDR_WIDTH-1:0]        dfi_addr,
  input  logic                         dfi_odt,
  input  logic [$clog2(MAX_DLY+1)-1:0] cfg_dly,
  input  logic                         cfg_2t,
  input  logic                         err_clr,
  output logic                         cmd_ready,
  output logic                         ck,
  output logic                         ck_n,
  output logic                         cke,
  output logic [CS_WIDTH-1:0]          cs_n,
  output logic                         ras_n,
  output logic                         cas_n,
  output logic                         we_n,
  output logic [BA_WIDTH-1:0]          ba,
  output logic [ADDR_WIDTH-1:0]        addr,
  output logic                         odt,
  output logic [CNT_WIDTH-1:0]         cmd_cnt,
`ifdef DDRPHY_CA_PARITY_EN
  output logic                         par,
`endif
  output logic                         overrun_err
);
  localparam int DW = $clog2(MAX_DLY+1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [CS_WIDTH-1:0] CS_IDLE = {CS_WIDTH{1'b1}};

  typedef struct packed {
    logic [CS_WIDTH-1:0]   cs_n;
    logic                  ras_n;
    logic                  cas_n;
    logic                  we_n;
    logic [BA_WIDTH-1:0]   ba;
    logic [ADDR_WIDTH-1:0] addr;
  } cmd_t;

  typedef struct packed {
    logic cke;
    logic odt;
    cmd_t cmd;
  } ca_t;

  localparam cmd_t CMD_NOP = '{cs_n: CS_IDLE, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
                               ba: {BA_WIDTH{1'b0}}, addr: {ADDR_WIDTH{1'b0}}};
  localparam ca_t  CA_NOP  = '{cke: 1'b0, odt: 1'b0, cmd: CMD_NOP};

  logic cmd_in, ready_q, err_q;
  ca_t  in_c;

  assign cmd_in    = (dfi_cs_n != CS_IDLE);
  assign cmd_ready = ready_q | ~cfg_2t;

  always_comb begin
    in_c = '{cke: dfi_cke, odt: dfi_odt,
             cmd: '{cs_n: dfi_cs_n, ras_n: dfi_ras_n, cas_n: dfi_cas_n, we_n: dfi_we_n,
                    ba: dfi_ba, addr: dfi_addr}};
    // A command offered while not ready is squashed here; cke/odt keep flowing.
    if (cmd_in && !cmd_ready) in_c.cmd = CMD_NOP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      ready_q <= !(cfg_2t && cmd_in && ready_q);
      if (cmd_in && !cmd_ready) err_q <= 1'b1;
      else if (err_clr)         err_q <= 1'b0;
    end
  end

  ca_t           pipe_q [MAX_DLY];
  logic [DW-1:0] dly_eff;
  ca_t           p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_DLY; i++) pipe_q[i] <= CA_NOP;
    end else begin
      pipe_q[0] <= in_c;
      for (int i = 1; i < MAX_DLY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dly_eff = (cfg_dly > DW'(MAX_DLY)) ? DW'(MAX_DLY) : cfg_dly;

  always_comb begin
    p = in_c;
    for (int i = 0; i < MAX_DLY; i++)
      if (dly_eff == DW'(i + 1)) p = pipe_q[i];
  end

  logic [0:0]           st_q, st_d;
  cmd_t                 lat_q, lat_d;
  ca_t                  pin_q, pin_d;
  logic [CNT_WIDTH-1:0] cnt_q;

  always_comb begin
    st_d      = st_q;
    lat_d     = lat_q;
    pin_d.cke = p.cke;
    pin_d.odt = p.odt;
    pin_d.cmd = '{cs_n: CS_IDLE, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
                  ba: pin_q.cmd.ba, addr: pin_q.cmd.addr};
    if (st_q == ST_HOLD) begin
      pin_d.cmd = lat_q;
      st_d      = ST_IDLE;
    end else if (p.cmd.cs_n != CS_IDLE) begin
      pin_d.cmd = p.cmd;
      // 2T: set up address/strobes one cycle ahead of the real chip select.
      if (cfg_2t) begin
        pin_d.cmd.cs_n = CS_IDLE;
        lat_d          = p.cmd;
        st_d           = ST_HOLD;
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      lat_q <= CMD_NOP;
      pin_q <= CA_NOP;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      lat_q <= lat_d;
      pin_q <= pin_d;
      cnt_q <= cnt_q + CNT_WIDTH'(pin_d.cmd.cs_n != CS_IDLE);
    end
  end

`ifdef DDRPHY_CA_PARITY_EN
  logic par_q;
  always_ff @(negedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= ^{pin_d.cmd.ras_n, pin_d.cmd.cas_n, pin_d.cmd.we_n, pin_d.cmd.ba, pin_d.cmd.addr};
  end
  assign par = par_q;
`endif

  assign ck          = clk;
  assign ck_n        = ~clk;
  assign cke         = pin_q.cke;
  assign odt         = pin_q.odt;
  assign cs_n        = pin_q.cmd.cs_n;
  assign ras_n       = pin_q.cmd.ras_n;
  assign cas_n       = pin_q.cmd.cas_n;
  assign we_n        = pin_q.cmd.we_n;
  assign ba          = pin_q.cmd.ba;
  assign addr        = pin_q.cmd.addr;
  assign cmd_cnt     = cnt_q;
  assign overrun_err = err_q;

endmodule

// File: tb/tb_ddrphy_cmd_launch.sv
// Bench for ddrphy_cmd_launch: directed vector table, hand sequences, and random streams vs an event-schedule model.
module tb_ddrphy_cmd_launch;
  localparam int CSW = 2, BAW = 3, AW = 14, MAXD = 7, CW = 16, NMAX = 96;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dfi_cke, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt, cfg_2t, err_clr;
  logic [CSW-1:0] dfi_cs_n;
  logic [BAW-1:0] dfi_ba;
  logic [AW-1:0]  dfi_addr;
  logic [2:0]     cfg_dly;
  logic cmd_ready, ck, ck_n, cke, ras_n, cas_n, we_n, odt, overrun_err;
  logic [CSW-1:0] cs_n;
  logic [BAW-1:0] ba;
  logic [AW-1:0]  addr;
  logic [CW-1:0]  cmd_cnt;
`ifdef DDRPHY_CA_PARITY_EN
  logic par;
  logic o_par [NMAX];
`endif

  ddrphy_cmd_launch #(.CS_WIDTH(CSW), .BA_WIDTH(BAW), .ADDR_WIDTH(AW), .MAX_DLY(MAXD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n),
    .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n), .dfi_ba(dfi_ba), .dfi_addr(dfi_addr),
    .dfi_odt(dfi_odt), .cfg_dly(cfg_dly), .cfg_2t(cfg_2t), .err_clr(err_clr),
    .cmd_ready(cmd_ready), .ck(ck), .ck_n(ck_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr), .odt(odt), .cmd_cnt(cmd_cnt),
`ifdef DDRPHY_CA_PARITY_EN
    .par(par),
`endif
    .overrun_err(overrun_err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic cke; logic [CSW-1:0] cs; logic ras, cas, we; logic [BAW-1:0] ba; logic [AW-1:0] addr; logic odt;
  } pin_t;
  typedef struct {
    logic cke, odt, clr; logic [CSW-1:0] cs; logic ras, cas, we; logic [BAW-1:0] ba; logic [AW-1:0] addr;
  } stim_t;
  typedef struct {
    int dly; bit t2; logic [CSW-1:0] cs; logic ras, cas, we; logic [BAW-1:0] ba; logic [AW-1:0] addr;
    logic [CSW-1:0] cs_first, cs_second; logic ready1; int cnt;
  } vec_t;

  localparam pin_t RST_PIN = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 3'd0, 14'd0, 1'b0};
  localparam stim_t NOP_S  = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 3'd0, 14'd0};

  stim_t stim [NMAX];
  pin_t  e_pin [NMAX];
  pin_t  o_pin [NMAX];
  int    e_cnt [NMAX];
  int    o_cnt [NMAX];
  logic  e_ready [NMAX];
  logic  e_err [NMAX];
  logic  o_ready [NMAX];
  logic  o_err [NMAX];
  int    last_t;
  int    n_err = 0, n_chk = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %h want %h", nm, k, act, exp);
    end
  endtask

  function automatic pin_t read_pins();
    pin_t r;
    r.cke = cke; r.cs = cs_n; r.ras = ras_n; r.cas = cas_n; r.we = we_n;
    r.ba = ba; r.addr = addr; r.odt = odt;
    return r;
  endfunction

  task automatic drive(input stim_t s);
    dfi_cke = s.cke; dfi_odt = s.odt; err_clr = s.clr; dfi_cs_n = s.cs;
    dfi_ras_n = s.ras; dfi_cas_n = s.cas; dfi_we_n = s.we; dfi_ba = s.ba; dfi_addr = s.addr;
  endtask

  // Reference: decide acceptance per input cycle, then schedule launch slots at cycle+delay.
  task automatic build_model(input int t, input int d, input bit t2);
    int   kind [NMAX];
    int   src [NMAX];
    bit   rdy, err, cmd, acc;
    int   cnt;
    pin_t prev, pp;
    for (int k = 0; k < NMAX; k++) begin kind[k] = 0; src[k] = 0; end
    rdy = 1; err = 0;
    for (int j = 0; j < t; j++) begin
      e_ready[j] = rdy; e_err[j] = err;
      cmd = (stim[j].cs != 2'b11);
      acc = cmd && (rdy || !t2);
      err = (cmd && !acc) || (err && !stim[j].clr);
      rdy = !(t2 && acc);
      if (acc && t2) begin
        kind[j+d] = 1; src[j+d] = j; kind[j+d+1] = 2; src[j+d+1] = j;
      end else if (acc) begin
        kind[j+d] = 2; src[j+d] = j;
      end
    end
    prev = RST_PIN; cnt = 0;
    for (int k = 0; k < t; k++) begin
      pp = prev;
      pp.cke = (k >= d) ? stim[k-d].cke : 1'b0;
      pp.odt = (k >= d) ? stim[k-d].odt : 1'b0;
      pp.cs = 2'b11; pp.ras = 1'b1; pp.cas = 1'b1; pp.we = 1'b1;
      if (kind[k] != 0) begin
        pp.ras = stim[src[k]].ras; pp.cas = stim[src[k]].cas; pp.we = stim[src[k]].we;
        pp.ba = stim[src[k]].ba; pp.addr = stim[src[k]].addr;
        if (kind[k] == 2) pp.cs = stim[src[k]].cs;
      end
      if (pp.cs != 2'b11) cnt++;
      e_pin[k] = pp; e_cnt[k] = cnt; prev = pp;
    end
  endtask

  task automatic run_stream(input int n, input int d, input bit t2);
    int t;
    t = n + d + 3;
    last_t = t;
    for (int j = n; j < t; j++) stim[j] = NOP_S;
    build_model(t, d, t2);
    rst = 1'b1; drive(NOP_S); cfg_dly = 3'(d); cfg_2t = t2;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < t; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      o_ready[k] = cmd_ready; o_err[k] = overrun_err;
      chk("cmd_ready", k, 32'(cmd_ready), 32'(e_ready[k]));
      chk("overrun_err", k, 32'(overrun_err), 32'(e_err[k]));
      drive(stim[k]);
      @(negedge clk); #1;
      o_pin[k] = read_pins(); o_cnt[k] = int'(cmd_cnt);
      chk("pins", k, 32'(o_pin[k]), 32'(e_pin[k]));
      chk("cmd_cnt", k, 32'(cmd_cnt), 32'(e_cnt[k]));
`ifdef DDRPHY_CA_PARITY_EN
      o_par[k] = par;
      chk("par", k, 32'(par), 32'(^{e_pin[k].ras, e_pin[k].cas, e_pin[k].we, e_pin[k].ba, e_pin[k].addr}));
`endif
    end
  endtask

  vec_t vt [5];
  int   cfgs [5][2];
  stim_t s;

  initial begin
    vt[0] = '{0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 3'd2, 14'h1A5, 2'b10, 2'b11, 1'b1, 1};
    vt[1] = '{3, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 3'd2, 14'h1A5, 2'b10, 2'b11, 1'b1, 1};
    vt[2] = '{7, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 3'd2, 14'h1A5, 2'b10, 2'b11, 1'b1, 1};
    vt[3] = '{1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 3'd5, 14'h040, 2'b11, 2'b01, 1'b0, 1};
    vt[4] = '{0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 3'd7, 14'h3FFF, 2'b11, 2'b00, 1'b0, 1};

    // Reset state, with a command held on the inputs throughout.
    s = NOP_S; s.cs = 2'b00; s.ras = 1'b0; s.addr = 14'h1234;
    drive(s); cfg_dly = 3'd0; cfg_2t = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins", 0, 32'(read_pins()), 32'(RST_PIN));
    chk("rst_ready", 0, 32'(cmd_ready), 32'd1);
    chk("rst_err", 0, 32'(overrun_err), 32'd0);
    @(negedge clk); #1;
    chk("rst_pins_neg", 0, 32'(read_pins()), 32'(RST_PIN));
    chk("rst_cnt", 0, 32'(cmd_cnt), 32'd0);
    @(posedge clk); #1 rst = 1'b0; drive(NOP_S);
    @(negedge clk); #1;
    chk("rel_cs", 0, 32'(cs_n), 32'h3);
    chk("rel_cnt", 0, 32'(cmd_cnt), 32'd0);

    // Single-command vectors.
    for (int i = 0; i < 5; i++) begin
      s = NOP_S; s.cs = vt[i].cs; s.ras = vt[i].ras; s.cas = vt[i].cas; s.we = vt[i].we;
      s.ba = vt[i].ba; s.addr = vt[i].addr; s.odt = 1'b1;
      stim[0] = s;
      run_stream(1, vt[i].dly, vt[i].t2);
      if (vt[i].dly > 0) chk("vec_before_cs", i, 32'(o_pin[vt[i].dly-1].cs), 32'h3);
      chk("vec_first_cs", i, 32'(o_pin[vt[i].dly].cs), 32'(vt[i].cs_first));
      chk("vec_first_str", i, 32'({o_pin[vt[i].dly].ras, o_pin[vt[i].dly].cas, o_pin[vt[i].dly].we}),
          32'({vt[i].ras, vt[i].cas, vt[i].we}));
      chk("vec_first_addr", i, 32'({o_pin[vt[i].dly].ba, o_pin[vt[i].dly].addr}), 32'({vt[i].ba, vt[i].addr}));
      chk("vec_second_cs", i, 32'(o_pin[vt[i].dly+1].cs), 32'(vt[i].cs_second));
      chk("vec_second_addr", i, 32'(o_pin[vt[i].dly+1].addr), 32'(vt[i].addr));
      chk("vec_ready1", i, 32'(o_ready[1]), 32'(vt[i].ready1));
      chk("vec_cnt", i, 32'(o_cnt[last_t-1]), 32'(vt[i].cnt));
    end

    // 2T overrun, clear, and set-beats-clear.
    for (int j = 0; j < 9; j++) stim[j] = NOP_S;
    s = NOP_S; s.cs = 2'b10; s.cas = 1'b0; s.we = 1'b0; s.ba = 3'd1; s.addr = 14'h0AA;
    stim[0] = s; stim[6] = s;
    s.addr = 14'h155; stim[1] = s;
    s.clr = 1'b1; stim[7] = s;
    stim[4].clr = 1'b1;
    run_stream(9, 1, 1'b1);
    chk("ovr_ready", 1, 32'(o_ready[1]), 32'd0);
    chk("ovr_set", 2, 32'(o_err[2]), 32'd1);
    chk("ovr_dropped_cs", 3, 32'(o_pin[3].cs), 32'h3);
    chk("ovr_clr", 5, 32'(o_err[5]), 32'd0);
    chk("ovr_set_wins", 8, 32'(o_err[8]), 32'd1);
    chk("ovr_cnt", 0, 32'(o_cnt[last_t-1]), 32'd2);

    // Asynchronous reset while the FSM holds a 2T command.
    rst = 1'b1; drive(NOP_S); cfg_dly = 3'd0; cfg_2t = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    s = NOP_S; s.cs = 2'b10; s.cas = 1'b0; s.we = 1'b0; s.ba = 3'd3; s.addr = 14'h155;
    drive(s);
    @(negedge clk); #1;
    chk("hold_pre_cs", 0, 32'(cs_n), 32'h3);
    chk("hold_pre_cas", 0, 32'(cas_n), 32'd0);
    @(posedge clk); #1 drive(NOP_S);
    #1 rst = 1'b1;
    #1;
    chk("hold_rst_pins", 0, 32'(read_pins()), 32'(RST_PIN));
    chk("hold_rst_cnt", 0, 32'(cmd_cnt), 32'd0);
    @(negedge clk); #1;
    chk("hold_rst_neg_cs", 0, 32'(cs_n), 32'h3);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("hold_after_cs", k, 32'(cs_n), 32'h3);
      chk("hold_after_cnt", k, 32'(cmd_cnt), 32'd0);
      @(posedge clk); #1;
    end

`ifdef DDRPHY_CA_PARITY_EN
    s = NOP_S; s.cs = 2'b10; s.ras = 1'b1; s.cas = 1'b1; s.we = 1'b0; s.ba = 3'd0; s.addr = 14'h0001;
    stim[0] = s;
    run_stream(1, 0, 1'b0);
    chk("par_vec", 0, 32'(o_par[0]), 32'd1);
`endif

    // Random streams against the model.
    cfgs[0] = '{2, 0}; cfgs[1] = '{1, 1}; cfgs[2] = '{0, 1}; cfgs[3] = '{5, 1}; cfgs[4] = '{0, 0};
    for (int c = 0; c < 5; c++) begin
      for (int j = 0; j < 60; j++) begin
        s.cke = 1'($urandom); s.odt = 1'($urandom); s.clr = ($urandom_range(0, 9) == 0);
        s.cs = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        s.ras = 1'($urandom); s.cas = 1'($urandom); s.we = 1'($urandom);
        s.ba = 3'($urandom); s.addr = 14'($urandom);
        stim[j] = s;
      end
      run_stream(60, cfgs[c][0], cfgs[c][1] != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ddrphy_cmd_launch.md
# ddrphy_cmd_launch

Parametrised command/address launch stage of the DDR PHY. Sits between the controller's DFI control signals and the DRAM command pins. Provides:
- a programmable posedge delay pipeline;
- final half-cycle (negedge) launch so command/address is centred on CK;
- an optional 2T command mode with issue back-pressure;
- an issued-command counter and an overrun error flag.

## Interface
Parameters:
- `CS_WIDTH`, 1: number of chip selects (ranks).
- `BA_WIDTH`, 3: bank address width.
- `ADDR_WIDTH`, 14: row/column address width.
- `MAX_DLY`, 7: maximum programmable pipeline delay in clk cycles (≥1).
- `CNT_WIDTH`, 16: issued-command counter width.

Ports:
- `clk`, in, 1: PHY clock. Also forwarded as `ck` / `ck_n`.
- `rst`, in, 1: asynchronous, active-high reset. Applies to posedge and negedge registers.
- `dfi_cke`, in, 1: clock enable from controller.
- `dfi_cs_n`, in, CS_WIDTH: chip selects. All ones means NOP.
- `dfi_ras_n`, `dfi_cas_n`, `dfi_we_n`, in, 1 each: command strobes.
- `dfi_ba`, in, BA_WIDTH: bank address.
- `dfi_addr`, in, ADDR_WIDTH: address.
- `dfi_odt`, in, 1: on-die termination.
- `cfg_dly`, in, $clog2(MAX_DLY+1): posedge pipeline depth. Static; change only while idle.
- `cfg_2t`, in, 1: 2T mode. Static; change only while idle.
- `err_clr`, in, 1: clears `overrun_err`.
- `cmd_ready`, out, 1: high when a command can be accepted this cycle.
- `ck`, `ck_n`, out, 1 each: `clk` and `~clk`.
- `cke`, `cs_n`, `ras_n`, `cas_n`, `we_n`, `ba`, `addr`, `odt`, out: DRAM pins. Widths match the corresponding inputs.
- `cmd_cnt`, out, CNT_WIDTH: count of commands launched on pins.
- `overrun_err`, out, 1: sticky; set when a command arrives while `cmd_ready` is 0.

## Operation
- Command definition: any cycle with `dfi_cs_n != '1` is a command. All other cycles are NOPs.
- Delay pipeline:
  - All inputs pass through `cfg_dly` posedge stages.
  - `cfg_dly = 0` bypasses the pipeline: inputs feed the negedge stage directly.
  - Values above `MAX_DLY` clamp to `MAX_DLY`.
- Launch: the pipeline output is registered on negedge `clk` into the pin registers.
- 1T mode (`cfg_2t = 0`):
  - Commands pass through unchanged.
  - `cmd_ready` is held at 1.
- 2T mode (`cfg_2t = 1`): a two-state FSM, IDLE and HOLD, at the pipeline output.
  - IDLE, command seen: drive ras/cas/we/ba/addr with `cs_n` all ones, latch the command, go to HOLD.
  - HOLD: drive the latched command with its real `cs_n`, return to IDLE.
  - After a command is accepted, `cmd_ready` drops for exactly one cycle, the cycle after acceptance at the input.
  - A command presented while `cmd_ready = 0` is dropped (never launched) and sets `overrun_err`.
- NOP outputs:
  - ras/cas/we go to 1; cs_n to all ones.
  - ba/addr hold their last value.
- `cke` and `odt` bypass 2T stretching. They follow the pipeline with the same delay.
- `cmd_cnt` increments by 1 on each negedge where the launched `cs_n != '1`. It wraps at 2^CNT_WIDTH.
- `overrun_err`:
  - If set and `err_clr` arrive in the same cycle, set wins.
  - `err_clr` is sampled on posedge.

## Timing
- Reset values:
  - `cke = 0`, `cs_n = '1`, `ras_n = cas_n = we_n = 1`, `ba = 0`, `addr = 0`, `odt = 0`.
  - `cmd_ready = 1`, `cmd_cnt = 0`, `overrun_err = 0`.
  - Pipeline stages reset to NOP.
  - FSM resets to IDLE.
- 1T latency: input sampled at posedge k appears on pins at the negedge following posedge k+`cfg_dly`, i.e. `cfg_dly + 0.5` cycles.
- 2T latency:
  - First cycle (cs_n high) at the same point as 1T.
  - Asserted cs_n one cycle later.
- Reset asserted mid-2T-HOLD:
  - Pins go to reset values immediately (asynchronously).
  - The latched command is discarded and not counted.
- Back-to-back 1T commands launch on consecutive negedges.

## Configuration
- `DDRPHY_CA_PARITY_EN` defined:
  - Adds output `par`, width 1.
  - `par` is the even parity (XOR) of ras_n, cas_n, we_n, ba and addr as launched.
  - Registered on the same negedge as the pins; reset value 0.
- Not defined: the `par` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset check: hold `rst` high, toggle clk → all pins at their reset values. Release → still NOP and `cmd_cnt = 0`.
- 1T delay sweep, `cfg_dly` = 0, 3, 7: ACT (`cs_n = 0`, ras_n = 0, ba = 2, addr = 0x1A5) → pins show it at the negedge `cfg_dly` cycles later, for one cycle; `cmd_cnt = 1`.
- 2T mode, `cfg_dly = 1`: issue RD, then NOP → first pin cycle has `cs_n = 1`, cas_n = 0; second cycle has `cs_n = 0`. `cmd_ready` is low for one cycle; `cmd_cnt = 1`.
- 2T overrun: issue WR on two consecutive cycles → second is dropped and `overrun_err = 1`. `err_clr` pulse → 0. Simultaneous overrun and `err_clr` → stays 1.
- Async reset during HOLD → pins return to NOP within the same cycle, with no asserted cs_n afterwards. `cmd_cnt` is unchanged by the aborted command.
- With `DDRPHY_CA_PARITY_EN` defined, addr = 0x0001, ba = 0, ras/cas/we = 1/1/0 → `par = 1` (three ones, odd count).
